// File: rtl/canvas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : canvas_pkg
// Description : Shared canvas constants, colour palette and draw-FSM state
//               type. Used by the draw controller, the frame-buffer RAM
//               instantiation and the VGA reader.
// Revision    : 1.0 - initial release
// ============================================================================
package canvas_pkg;

    localparam int X_BITS    = 8;
    localparam int Y_BITS    = 8;
    localparam int ADDR_SIZE = X_BITS + Y_BITS;
    localparam int DATA_SIZE = 3;

    // Palette, one bit per RGB primary
    localparam logic [DATA_SIZE-1:0] COLOR_BLACK   = 3'b000;
    localparam logic [DATA_SIZE-1:0] COLOR_BLUE    = 3'b001;
    localparam logic [DATA_SIZE-1:0] COLOR_GREEN   = 3'b010;
    localparam logic [DATA_SIZE-1:0] COLOR_CYAN    = 3'b011;
    localparam logic [DATA_SIZE-1:0] COLOR_RED     = 3'b100;
    localparam logic [DATA_SIZE-1:0] COLOR_MAGENTA = 3'b101;
    localparam logic [DATA_SIZE-1:0] COLOR_YELLOW  = 3'b110;
    localparam logic [DATA_SIZE-1:0] COLOR_WHITE   = 3'b111;

    localparam logic [DATA_SIZE-1:0] BG_COLOR = COLOR_BLACK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2
    } draw_state_e;

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Converts a held level into rate-limited step pulses. The
//               first pulse comes on the first enabled held cycle, then one
//               every MOVE_DIV cycles while the level stays high.
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
    parameter int MOVE_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic held_i,
    output logic step_o
);

    localparam int              CNT_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOVE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..MOVE_DIV-1 while held and enabled, otherwise park at zero
    always_comb begin
        cnt_d = '0;
        if (en_i && held_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_o = en_i && held_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/canvas_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : canvas_draw_ctrl
// Description : Port-A write driver for the frame-buffer RAM. Walks a cursor
//               from held direction buttons, stamps the ink colour under the
//               cursor while the pen is down, and sweeps a full clear.
// Revision    : 1.0 - initial release
// ============================================================================
module canvas_draw_ctrl #(
    parameter int                              X_BITS    = canvas_pkg::X_BITS,
    parameter int                              Y_BITS    = canvas_pkg::Y_BITS,
    parameter int                              DATA_SIZE = canvas_pkg::DATA_SIZE,
    parameter int                              MOVE_DIV  = 1_000_000,
    parameter logic [DATA_SIZE-1:0]            BG_COLOR  = canvas_pkg::BG_COLOR,
    parameter int                              X_INIT    = 128,
    parameter int                              Y_INIT    = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        pen_down,
    input  logic [DATA_SIZE-1:0]        color_sel,
    input  logic                        clear_req,
    output logic                        we,
    output logic [X_BITS+Y_BITS-1:0]    addr_a,
    output logic [DATA_SIZE-1:0]        din_a,
    output logic [X_BITS-1:0]           cursor_x,
    output logic [Y_BITS-1:0]           cursor_y,
    output logic                        busy
);

    import canvas_pkg::*;

    localparam int                  ADDR_W    = X_BITS + Y_BITS;
    localparam logic [X_BITS-1:0]   X_MAX     = '1;
    localparam logic [Y_BITS-1:0]   Y_MAX     = '1;
    // Sweep counter is one bit wider so reaching 2**ADDR_W is visible
    localparam logic [ADDR_W:0]     SWEEP_END = {1'b1, {ADDR_W{1'b0}}};

    draw_state_e            state_q, state_d;
    logic [X_BITS-1:0]      x_q, x_d;
    logic [Y_BITS-1:0]      y_q, y_d;
    logic                   pen_q, pen_d;
    // Events arriving during the DRAW pulse are replayed on the next IDLE cycle
    logic                   pstep_q, pstep_d;
    logic                   pstamp_q, pstamp_d;
    logic                   pclr_q, pclr_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_SIZE-1:0]   din_q, din_d;
    logic                   busy_q, busy_d;
    logic [ADDR_W:0]        sweep_q, sweep_d;

    logic                   w_any_btn;
    logic                   w_go_clear;
    logic                   w_timer_en;
    logic                   w_step;
    logic                   w_pen_rise;
    logic                   w_do_step;
    logic                   w_do_stamp;

    assign w_any_btn  = btn_up | btn_down | btn_left | btn_right;
    assign w_go_clear = (state_q == IDLE) && (clear_req || pclr_q);
    // Timer is held at zero through the sweep and on the cycle a clear starts
    assign w_timer_en = (state_q != CLEAR) && !w_go_clear;
    assign w_pen_rise = pen_down && !pen_q;

    step_timer #(
        .MOVE_DIV (MOVE_DIV)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (w_timer_en),
        .held_i (w_any_btn),
        .step_o (w_step)
    );

    // Next-state, cursor update and write-port outputs
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        pen_d      = pen_q;
        pstep_d    = pstep_q;
        pstamp_d   = pstamp_q;
        pclr_d     = pclr_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        busy_d     = busy_q;
        sweep_d    = sweep_q;
        w_do_step  = 1'b0;
        w_do_stamp = 1'b0;

        case (state_q)
            IDLE: begin
                pen_d    = pen_down;
                pstep_d  = 1'b0;
                pstamp_d = 1'b0;
                pclr_d   = 1'b0;
                if (w_go_clear) begin
                    // Clear wins over any coincident step or stamp
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    din_d   = BG_COLOR;
                    sweep_d = {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    w_do_step  = w_step || pstep_q;
                    w_do_stamp = w_pen_rise || pstamp_q;
                    if (w_do_step) begin
                        if (btn_right && !btn_left && (x_q != X_MAX)) begin
                            x_d = x_q + 1'b1;
                        end else if (btn_left && !btn_right && (x_q != '0)) begin
                            x_d = x_q - 1'b1;
                        end
                        if (btn_down && !btn_up && (y_q != Y_MAX)) begin
                            y_d = y_q + 1'b1;
                        end else if (btn_up && !btn_down && (y_q != '0)) begin
                            y_d = y_q - 1'b1;
                        end
                    end
                    if ((w_do_step && pen_down) || w_do_stamp) begin
                        state_d = DRAW;
                    end
                end
            end

            DRAW: begin
                // Cursor already holds the new position; stamp it now
                state_d  = IDLE;
                we_d     = 1'b1;
                addr_d   = {y_q, x_q};
                din_d    = color_sel;
                pen_d    = pen_down;
                pstep_d  = w_step;
                pstamp_d = w_pen_rise;
                pclr_d   = clear_req;
            end

            CLEAR: begin
                if (sweep_q == SWEEP_END) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    // Re-sample so a pen held through the sweep does not stamp
                    pen_d   = pen_down;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = sweep_q[ADDR_W-1:0];
                    sweep_d = sweep_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= X_BITS'(X_INIT);
            y_q      <= Y_BITS'(Y_INIT);
            pen_q    <= 1'b0;
            pstep_q  <= 1'b0;
            pstamp_q <= 1'b0;
            pclr_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            sweep_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pen_q    <= pen_d;
            pstep_q  <= pstep_d;
            pstamp_q <= pstamp_d;
            pclr_q   <= pclr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            sweep_q  <= sweep_d;
        end
    end

    assign we       = we_q;
    assign addr_a   = addr_q;
    assign din_a    = din_q;
    assign cursor_x = x_q;
    assign cursor_y = y_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_canvas_draw_ctrl
// Description : Directed bench for canvas_draw_ctrl. An 8-bit canvas instance
//               covers cursor walk, stamping and a randomised model run; a
//               4-bit canvas instance covers the clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_canvas_draw_ctrl;

    logic       clk = 1'b0;
    logic       rst8, rst4;
    logic       clr8, clr4;
    logic [3:0] btn;            // {up, down, left, right}
    logic       pen;
    logic [2:0] color;

    logic        d8_we, d8_busy;
    logic [15:0] d8_addr;
    logic [2:0]  d8_din;
    logic [7:0]  d8_x, d8_y;

    logic        d4_we, d4_busy;
    logic [7:0]  d4_addr;
    logic [2:0]  d4_din;
    logic [3:0]  d4_x, d4_y;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    canvas_draw_ctrl #(
        .X_BITS(8), .Y_BITS(8), .DATA_SIZE(3), .MOVE_DIV(4),
        .BG_COLOR(3'b000), .X_INIT(128), .Y_INIT(128)
    ) u_dut8 (
        .clk(clk), .reset(rst8),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .pen_down(pen), .color_sel(color), .clear_req(clr8),
        .we(d8_we), .addr_a(d8_addr), .din_a(d8_din),
        .cursor_x(d8_x), .cursor_y(d8_y), .busy(d8_busy)
    );

    canvas_draw_ctrl #(
        .X_BITS(4), .Y_BITS(4), .DATA_SIZE(3), .MOVE_DIV(4),
        .BG_COLOR(3'b000), .X_INIT(8), .Y_INIT(8)
    ) u_dut4 (
        .clk(clk), .reset(rst4),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .pen_down(pen), .color_sel(color), .clear_req(clr4),
        .we(d4_we), .addr_a(d4_addr), .din_a(d4_din),
        .cursor_x(d4_x), .cursor_y(d4_y), .busy(d4_busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomised run
    logic [7:0] m_x, m_y;
    int         m_cnt;
    logic       m_pen, m_draw, m_hstep, m_hstamp;
    logic       e_we;
    logic [15:0] e_addr;
    logic [2:0]  e_din;

    task automatic model_cycle();
        logic fire, stp, stamp;
        int   n_cnt;
        fire  = (btn != 4'b0) && (m_cnt == 0);
        n_cnt = (btn != 4'b0) ? ((m_cnt == 3) ? 0 : m_cnt + 1) : 0;
        e_we  = 1'b0;
        if (m_draw) begin
            e_we     = 1'b1;
            e_addr   = {m_y, m_x};
            e_din    = color;
            m_draw   = 1'b0;
            m_hstep  = fire;
            m_hstamp = pen && !m_pen;
        end else begin
            stp      = fire || m_hstep;
            stamp    = (pen && !m_pen) || m_hstamp;
            m_hstep  = 1'b0;
            m_hstamp = 1'b0;
            if (stp) begin
                if (btn[0] && !btn[1] && m_x != 8'd255) m_x = m_x + 8'd1;
                else if (btn[1] && !btn[0] && m_x != 8'd0) m_x = m_x - 8'd1;
                if (btn[2] && !btn[3] && m_y != 8'd255) m_y = m_y + 8'd1;
                else if (btn[3] && !btn[2] && m_y != 8'd0) m_y = m_y - 8'd1;
            end
            if ((stp && pen) || stamp) m_draw = 1'b1;
        end
        m_pen = pen;
        m_cnt = n_cnt;
    endtask

    initial begin
        int  nw;
        int  exp_x;
        logic found;

        rst8 = 1'b1; rst4 = 1'b1; clr8 = 1'b0; clr4 = 1'b0;
        btn = 4'b0; pen = 1'b0; color = 3'd0;
        tick(); tick();
        rst8 = 1'b0; rst4 = 1'b0;
        tick();

        // Reset state
        chk_eq("rst_we",   d8_we,   0);
        chk_eq("rst_addr", d8_addr, 0);
        chk_eq("rst_din",  d8_din,  0);
        chk_eq("rst_busy", d8_busy, 0);
        chk_eq("rst_x",    d8_x,    128);
        chk_eq("rst_y",    d8_y,    128);

        // Pen rising edge with no buttons stamps once at the cursor
        color = 3'd2; pen = 1'b1; nw = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk_eq("stamp_we", d8_we, (t == 2) ? 1 : 0);
            if (d8_we) begin
                nw++;
                chk_eq("stamp_addr", d8_addr, 16'h8080);
                chk_eq("stamp_din",  d8_din,  2);
            end
        end
        chk_eq("stamp_count", nw, 1);

        // Held right with pen down: steps on cycles 0,4,8, writes one cycle later
        color = 3'd5; btn = 4'b0001;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_x = (t >= 9) ? 131 : ((t >= 5) ? 130 : 129);
            chk_eq("walk_x",  d8_x, exp_x);
            chk_eq("walk_we", d8_we, (t == 2 || t == 6 || t == 10) ? 1 : 0);
            if (t == 2 || t == 6 || t == 10) begin
                chk_eq("walk_addr", d8_addr, {8'd128, exp_x[7:0]});
                chk_eq("walk_din",  d8_din,  5);
            end
        end
        chk_eq("walk_y", d8_y, 128);

        // Saturation at the right edge, diagonal, opposite-button cancel, top edge
        pen = 1'b0;
        for (int c = 0; c < 1100 && d8_x != 8'd255; c++) tick();
        chk_eq("sat_reach_x", d8_x, 255);
        btn = 4'b0; tick(); tick();
        btn = 4'b1001;
        tick();
        chk_eq("diag1_x", d8_x, 255);
        chk_eq("diag1_y", d8_y, 127);
        for (int t = 0; t < 7; t++) tick();
        chk_eq("diag2_x", d8_x, 255);
        chk_eq("diag2_y", d8_y, 126);
        btn = 4'b0; tick(); tick();
        btn = 4'b0011;
        for (int t = 0; t < 8; t++) tick();
        chk_eq("cancel_x", d8_x, 255);
        chk_eq("cancel_y", d8_y, 126);
        btn = 4'b0; tick(); tick();
        btn = 4'b1000;
        for (int t = 0; t < 520; t++) tick();
        chk_eq("top_y", d8_y, 0);
        chk_eq("top_x", d8_x, 255);
        btn = 4'b0;

        // Randomised run against the reference model
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        m_x = 8'd128; m_y = 8'd128; m_cnt = 0; m_pen = 1'b0;
        m_draw = 1'b0; m_hstep = 1'b0; m_hstamp = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(7) == 0) btn = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) pen = ~pen;
            color = 3'($urandom_range(7));
            model_cycle();
            tick();
            chk_eq("rnd_x",  d8_x,  m_x);
            chk_eq("rnd_y",  d8_y,  m_y);
            chk_eq("rnd_we", d8_we, e_we);
            if (e_we) begin
                chk_eq("rnd_addr", d8_addr, e_addr);
                chk_eq("rnd_din",  d8_din,  e_din);
            end
        end
        btn = 4'b0; pen = 1'b0;

        // Reset in the middle of a sweep aborts it
        rst4 = 1'b1; tick(); rst4 = 1'b0; tick();
        clr4 = 1'b1; tick(); clr4 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (d4_we && d4_addr == 8'd37) found = 1'b1;
            else tick();
        end
        chk_eq("abort_reach37", found, 1);
        rst4 = 1'b1; #1;
        chk_eq("abort_we_async",   d4_we,   0);
        chk_eq("abort_busy_async", d4_busy, 0);
        tick();
        chk_eq("abort_we",   d4_we,   0);
        chk_eq("abort_busy", d4_busy, 0);
        chk_eq("abort_x",    d4_x,    8);
        chk_eq("abort_y",    d4_y,    8);
        rst4 = 1'b0;
        nw = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (d4_we) nw++;
        end
        chk_eq("abort_no_writes", nw, 0);

        // Clear coincident with a step, repeat request ignored, pen held through
        tick(); tick();
        btn = 4'b0001; clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk_eq("clr_busy_rise", d4_busy, 1);
        chk_eq("clr_first_we",  d4_we,   1);
        chk_eq("clr_first_addr", d4_addr, 0);
        chk_eq("clr_no_move",   d4_x,    8);
        nw = 1;
        pen = 1'b1;
        for (int c = 0; c < 400 && nw < 256; c++) begin
            clr4 = (nw == 100);
            if (nw == 200) btn = 4'b0;
            tick();
            if (d4_we) begin
                chk_eq("clr_addr", d4_addr, nw);
                chk_eq("clr_din",  d4_din,  0);
                nw++;
            end else begin
                chk_eq("clr_gap", d4_we, 1);
                nw = 999;
            end
        end
        clr4 = 1'b0;
        chk_eq("clr_count", nw, 256);
        chk_eq("clr_busy_last", d4_busy, 1);
        tick();
        chk_eq("clr_busy_end", d4_busy, 0);
        chk_eq("clr_we_end",   d4_we,   0);
        chk_eq("clr_frozen_x", d4_x,    8);
        nw = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (d4_we) nw++;
        end
        chk_eq("clr_no_stamp", nw, 0);
        pen = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
